// File: rtl/tinker_pkg.sv
// Shared decode definitions for the Tinker pipeline: opcodes, control words,
// the decoded bundle and the instruction decoder.
package tinker_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_ADDI   = 5'h01;
    localparam logic [4:0] OP_SUB    = 5'h02;
    localparam logic [4:0] OP_AND    = 5'h06;
    localparam logic [4:0] OP_OR     = 5'h07;
    localparam logic [4:0] OP_XOR    = 5'h08;
    localparam logic [4:0] OP_NOT    = 5'h09;
    localparam logic [4:0] OP_SHIFTR = 5'h0A;
    localparam logic [4:0] OP_MOV    = 5'h17;
    localparam logic [4:0] OP_LD     = 5'h1D;
    localparam logic [4:0] OP_ST     = 5'h1E;
    localparam logic [4:0] OP_NOP    = 5'h1F;

    localparam logic [12:0] CTRL_ADD    = 13'h0106;
    localparam logic [12:0] CTRL_SUB    = 13'h0116;
    localparam logic [12:0] CTRL_AND    = 13'h0316;
    localparam logic [12:0] CTRL_OR     = 13'h0326;
    localparam logic [12:0] CTRL_XOR    = 13'h0336;
    localparam logic [12:0] CTRL_SHIFTR = 13'h0506;
    localparam logic [12:0] CTRL_NOT    = 13'h0305;
    localparam logic [12:0] CTRL_ADDI   = 13'h0030;
    localparam logic [12:0] CTRL_MOV    = 13'h1EB4;
    localparam logic [12:0] CTRL_ST     = 13'h003A;
    localparam logic [12:0] CTRL_LD     = 13'h0075;
    localparam logic [12:0] CTRL_NOP    = 13'h1F30;

    typedef struct packed {
        logic [12:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [11:0] imm;
        logic        we;
        logic        rs_used;
        logic        rt_used;
        logic        illegal;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t d;
        d      = '0;
        d.ctrl = CTRL_NOP;
        case (instr[4:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFTR: begin
                case (instr[4:0])
                    OP_ADD:  d.ctrl = CTRL_ADD;
                    OP_SUB:  d.ctrl = CTRL_SUB;
                    OP_AND:  d.ctrl = CTRL_AND;
                    OP_OR:   d.ctrl = CTRL_OR;
                    OP_XOR:  d.ctrl = CTRL_XOR;
                    default: d.ctrl = CTRL_SHIFTR;
                endcase
                d.rd      = instr[9:5];
                d.rs      = instr[14:10];
                d.rt      = instr[19:15];
                d.we      = 1'b1;
                d.rs_used = 1'b1;
                d.rt_used = 1'b1;
            end
            OP_NOT: begin
                d.ctrl    = CTRL_NOT;
                d.rd      = instr[9:5];
                d.rs      = instr[14:10];
                d.we      = 1'b1;
                d.rs_used = 1'b1;
            end
            OP_ADDI, OP_MOV: begin
                d.ctrl = (instr[4:0] == OP_ADDI) ? CTRL_ADDI : CTRL_MOV;
                d.rd   = instr[9:5];
                d.imm  = instr[31:20];
                d.we   = 1'b1;
            end
            OP_ST: begin
                // Store has no destination: [9:5] is the address source, [14:10] the data.
                d.ctrl    = CTRL_ST;
                d.rs      = instr[9:5];
                d.rt      = instr[14:10];
                d.rs_used = 1'b1;
                d.rt_used = 1'b1;
            end
            OP_LD: begin
                d.ctrl    = CTRL_LD;
                d.rd      = instr[14:10];
                d.rt      = instr[9:5];
                d.we      = 1'b1;
                d.rt_used = 1'b1;
            end
            OP_NOP: d.ctrl = CTRL_NOP;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-writeback counters with read-after-write hazard
// detection and a global in-flight limit.
module reg_scoreboard
    import tinker_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_rd,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rs,
    input  logic              rs_used,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rt_used,
    input  logic              we,
    output logic              hazard
);

    localparam int              CNT_W   = $clog2(MAX_INFLIGHT + 1);
    localparam int              NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt [NREG];
    logic [CNT_W-1:0] total;
    logic             wb_live;

    // A writeback to an idle register is ignored so counters saturate at zero.
    assign wb_live = wb_valid && (cnt[wb_addr] != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            total <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if ((acc_we && acc_rd == ADDR_W'(i)) && !(wb_live && wb_addr == ADDR_W'(i)))
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!(acc_we && acc_rd == ADDR_W'(i)) && (wb_live && wb_addr == ADDR_W'(i)))
                    cnt[i] <= cnt[i] - 1'b1;
            end
            if (acc_we && !wb_live)
                total <= total + 1'b1;
            else if (!acc_we && wb_live)
                total <= total - 1'b1;
        end
    end

    assign hazard = (rs_used && cnt[rs] != '0) ||
                    (rt_used && cnt[rt] != '0) ||
                    (we && total == MAX_CNT);

endmodule

// File: rtl/decode_stage.sv
// Registered Tinker instruction-decode stage with valid/ready output.
// Define DECODE_HAZARD_EN to build the RAW-hazard scoreboard.
module decode_stage
    import tinker_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int IMM_W        = 12,
    parameter int CTRL_W       = 13,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_rd,
    output logic [ADDR_W-1:0] out_rs,
    output logic [ADDR_W-1:0] out_rt,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_we,
    output logic              out_illegal,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              flush
);

    decode_t dec;
    logic    hazard;
    logic    accept;

    assign dec = decode_instr(instr);

`ifdef DECODE_HAZARD_EN
    reg_scoreboard #(
        .ADDR_W       (ADDR_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .acc_we   (accept && dec.we),
        .acc_rd   (ADDR_W'(dec.rd)),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .rs       (ADDR_W'(dec.rs)),
        .rs_used  (dec.rs_used),
        .rt       (ADDR_W'(dec.rt)),
        .rt_used  (dec.rt_used),
        .we       (dec.we),
        .hazard   (hazard)
    );
`else
    // Without the scoreboard, RAW spacing is the compiler's job.
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{wb_valid, wb_addr, dec.rs_used, dec.rt_used};
    assign hazard = 1'b0;
`endif

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    // Output register holds its bundle until the register stage takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_ctrl    <= CTRL_W'(CTRL_NOP);
            out_rd      <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_imm     <= '0;
            out_we      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_ctrl    <= CTRL_W'(dec.ctrl);
            out_rd      <= ADDR_W'(dec.rd);
            out_rs      <= ADDR_W'(dec.rs);
            out_rt      <= ADDR_W'(dec.rt);
            out_imm     <= IMM_W'(dec.imm);
            out_we      <= dec.we;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage; stall expectations follow DECODE_HAZARD_EN.
module tb_decode_stage;

`ifdef DECODE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic [12:0] out_ctrl;
    logic [4:0]  out_rd, out_rs, out_rt, wb_addr;
    logic [11:0] out_imm;
    logic        out_we, out_illegal, wb_valid, flush;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [12:0] ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [11:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
        .out_imm(out_imm), .out_we(out_we), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] f1,
                                       input logic [4:0] f2, input logic [4:0] f3,
                                       input logic [11:0] imm);
        return {imm, f3, f2, f1, op};
    endfunction

    // Reference decode written straight from the opcode table.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [4:0] a, b, c;
        a = ins[9:5]; b = ins[14:10]; c = ins[19:15];
        e = '0;
        e.ctrl = 13'h1F30;
        case (ins[4:0])
            5'h00: begin e.ctrl = 13'h0106; e.rd = a; e.rs = b; e.rt = c; e.we = 1; end
            5'h02: begin e.ctrl = 13'h0116; e.rd = a; e.rs = b; e.rt = c; e.we = 1; end
            5'h06: begin e.ctrl = 13'h0316; e.rd = a; e.rs = b; e.rt = c; e.we = 1; end
            5'h07: begin e.ctrl = 13'h0326; e.rd = a; e.rs = b; e.rt = c; e.we = 1; end
            5'h08: begin e.ctrl = 13'h0336; e.rd = a; e.rs = b; e.rt = c; e.we = 1; end
            5'h0A: begin e.ctrl = 13'h0506; e.rd = a; e.rs = b; e.rt = c; e.we = 1; end
            5'h09: begin e.ctrl = 13'h0305; e.rd = a; e.rs = b; e.we = 1; end
            5'h01: begin e.ctrl = 13'h0030; e.rd = a; e.imm = ins[31:20]; e.we = 1; end
            5'h17: begin e.ctrl = 13'h1EB4; e.rd = a; e.imm = ins[31:20]; e.we = 1; end
            5'h1E: begin e.ctrl = 13'h003A; e.rs = a; e.rt = b; end
            5'h1D: begin e.ctrl = 13'h0075; e.rd = b; e.rt = a; e.we = 1; end
            5'h1F: e.ctrl = 13'h1F30;
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Every completed output handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checkOutput("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("ctrl", 32'(out_ctrl), 32'(e.ctrl));
                checkOutput("rd", 32'(out_rd), 32'(e.rd));
                checkOutput("rs", 32'(out_rs), 32'(e.rs));
                checkOutput("rt", 32'(out_rt), 32'(e.rt));
                checkOutput("imm", 32'(out_imm), 32'(e.imm));
                checkOutput("we", 32'(out_we), 32'(e.we));
                checkOutput("illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
    end

    // One-cycle offer: drives the instruction, checks in_ready, records the expectation.
    task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic exp_rdy,
                                 input logic do_wb, input logic [4:0] wba, input logic do_flush);
        instr = ins; in_valid = 1'b1; wb_valid = do_wb; wb_addr = wba; flush = do_flush;
        @(negedge clk);
        checkOutput(tag, 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy) exp_q.push_back(model(ins));
        @(posedge clk); #1;
        in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic offer(input string tag, input logic [31:0] ins, input logic exp_rdy);
        applyStimulus(tag, ins, exp_rdy, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic retire(input logic [4:0] a);
        wb_valid = 1'b1; wb_addr = a;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1; in_valid = 0; instr = '0; out_ready = 1; wb_valid = 0; wb_addr = '0; flush = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_ctrl", 32'(out_ctrl), 32'h1F30);
        checkOutput("rst_fields", 32'({out_rd, out_rs, out_rt, out_imm}), 32'd0);
        checkOutput("rst_we_ill", 32'({out_we, out_illegal}), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd1);

        offer("add_ready", mk(5'h00, 5'd3, 5'd1, 5'd2, 12'h0), 1'b1);
        checkOutput("add_latency", 32'(out_valid), 32'd1);

        // RAW on r3: writeback in one cycle frees the reader in the next.
        offer("sub_stall", mk(5'h02, 5'd4, 5'd3, 5'd5, 12'h0), !HZ);
        applyStimulus("sub_wb_same_cycle", mk(5'h02, 5'd4, 5'd3, 5'd5, 12'h0), !HZ, 1'b1, 5'd3, 1'b0);
        offer("sub_after_wb", mk(5'h02, 5'd4, 5'd3, 5'd5, 12'h0), 1'b1);
        retire(5'd4);

        for (int i = 0; i < 4; i++)
            offer("writer_n", mk(5'h01, 5'(10 + i), 5'd0, 5'd0, 12'(12'h120 + i)), 1'b1);
        offer("fifth_writer", mk(5'h01, 5'd14, 5'd0, 5'd0, 12'h7FF), !HZ);
        offer("ld_rt_busy", mk(5'h1D, 5'd10, 5'd5, 5'd0, 12'h0), !HZ);
        offer("st_clean", mk(5'h1E, 5'd20, 5'd21, 5'd0, 12'h0), 1'b1);
        offer("nop_fields", mk(5'h1F, 5'd11, 5'd10, 5'd12, 12'hFFF), 1'b1);
        offer("illegal", mk(5'h15, 5'd10, 5'd11, 5'd12, 12'h5A5), 1'b1);

        applyStimulus("flush_ready", mk(5'h1D, 5'd10, 5'd5, 5'd0, 12'h0), 1'b0, 1'b1, 5'd10, 1'b1);
        checkOutput("flush_valid", 32'(out_valid), 32'd0);
        offer("ld_after_flush", mk(5'h1D, 5'd10, 5'd5, 5'd0, 12'h0), 1'b1);
        retire(5'd5);

        offer("and", mk(5'h06, 5'd20, 5'd1, 5'd2, 12'h0), 1'b1);
        offer("or", mk(5'h07, 5'd21, 5'd2, 5'd3, 12'h0), 1'b1);
        offer("shiftr", mk(5'h0A, 5'd22, 5'd3, 5'd4, 12'h0), 1'b1);
        offer("not", mk(5'h09, 5'd23, 5'd1, 5'd31, 12'h0), 1'b1);
        for (int i = 0; i < 4; i++) retire(5'(20 + i));

        // Backpressure: bundle must hold and no new instruction may enter.
        offer("mov", mk(5'h17, 5'd8, 5'd0, 5'd0, 12'hABC), 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer("bp_ready", mk(5'h08, 5'd9, 5'd1, 5'd2, 12'h0), 1'b0);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_ctrl", 32'(out_ctrl), 32'h1EB4);
            checkOutput("bp_imm_rd", 32'({out_imm, out_rd}), 32'({12'hABC, 5'd8}));
        end
        out_ready = 1'b1;
        offer("bp_release", mk(5'h08, 5'd9, 5'd1, 5'd2, 12'h0), 1'b1);

        // Reset in the middle of a stalled handshake drops the pending bundle.
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_ctrl", 32'(out_ctrl), 32'h1F30);
        out_ready = 1'b1;
        offer("reader_after_rst", mk(5'h02, 5'd4, 5'd8, 5'd9, 12'h0), 1'b1);
        repeat (2) @(posedge clk);
        #1 checkOutput("drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
